// File: rtl/axi_lite_master_v2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi_lite_master_v2
//  Purpose  : AXI4-Lite master. Turns a local command/response handshake into
//             single AXI4-Lite read or write transactions, one at a time.
//  Revision : 2.0 - parametrised widths, byte strobes, registered command
//             capture, independent AW/W tracking, held response handshake.
//
//  Ports
//    ACLK, ARESET        clock, asynchronous active-high reset
//    cmd_*               command request (valid/ready, write, addr, wdata, wstrb)
//    rsp_*               response (valid/ready, write, rdata, resp)
//    timeout             one-cycle watchdog pulse (0 unless AXIL_MST_TIMEOUT_EN)
//    AW*/W*/B*/AR*/R*    AXI4-Lite master channels
//
//  Build option
//    AXIL_MST_TIMEOUT_EN : when defined, a per-transaction watchdog pulses
//                          'timeout' once after TIMEOUT_CYCLES busy cycles.
// ============================================================================
module axi_lite_master_v2 #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // Local command interface
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // Local response interface
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout,
  // AXI write address channel
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  // AXI write response channel
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  // AXI read address channel
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // AXI read data channel
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("axi_lite_master_v2: DATA_WIDTH must be 32 or 64");
  end
  if ((ADDR_WIDTH < 2) || (ADDR_WIDTH > 32)) begin : g_bad_addr_width
    $error("axi_lite_master_v2: ADDR_WIDTH must be in 2..32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi_lite_master_v2: TIMEOUT_CYCLES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,   // AW and W outstanding
    S_WR_B = 3'd2,   // waiting for write response
    S_RD_A = 3'd3,   // AR outstanding
    S_RD_R = 3'd4,   // waiting for read data
    S_RSP  = 3'd5    // response held for local logic
  } state_t;

  state_t r_state;
  logic   r_aw_done;
  logic   r_w_done;

  logic w_cmd_acc;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_fin;
  logic w_w_fin;

  assign w_cmd_acc = cmd_valid & cmd_ready;
  assign w_aw_hs   = AWVALID & AWREADY;
  assign w_w_hs    = WVALID & WREADY;
  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_fin  = r_aw_done | w_aw_hs;
  assign w_w_fin   = r_w_done | w_w_hs;

  // Protection attributes: unprivileged, secure, data access.
  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              AWADDR    <= cmd_addr;
              WDATA     <= cmd_wdata;
              WSTRB     <= cmd_wstrb;
              AWVALID   <= 1'b1;
              WVALID    <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              r_state <= S_RD_A;
            end
          end
        end

        S_WR: begin
          // Each VALID drops on its own handshake; the other keeps waiting.
          if (w_aw_hs) begin
            AWVALID   <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            WVALID   <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            BREADY  <= 1'b1;
            r_state <= S_WR_B;
          end
        end

        S_WR_B: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= BRESP;
            r_state   <= S_RSP;
          end
        end

        S_RD_A: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            r_state <= S_RD_R;
          end
        end

        S_RD_R: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            r_state   <= S_RSP;
          end
        end

        S_RSP: begin
          // cmd_ready rises only after the response is consumed, so the next
          // command can be accepted no earlier than the following cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          AWVALID   <= 1'b0;
          WVALID    <= 1'b0;
          BREADY    <= 1'b0;
          ARVALID   <= 1'b0;
          RREADY    <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef AXIL_MST_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_FIRE  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_to_cnt;
  logic               w_busy;

  // RSP is excluded: once the slave has answered, waiting on local logic is
  // not an AXI stall.
  assign w_busy = (r_state == S_WR) || (r_state == S_WR_B) ||
                  (r_state == S_RD_A) || (r_state == S_RD_R);

  // The counter saturates at the limit, so the fire value is seen for exactly
  // one busy cycle per transaction.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_to_cnt <= '0;
    end else if (w_cmd_acc) begin
      r_to_cnt <= '0;
    end else if (w_busy && (r_to_cnt < c_CNT_LIMIT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout = w_busy && (r_to_cnt == c_CNT_FIRE);
`else
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_v2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_master_v2
//  Purpose  : Self-checking bench for axi_lite_master_v2. A behavioural AXI
//             slave with programmable per-channel wait states serves the DUT;
//             a word-array reference model predicts every response.
//  Revision : 2.0
// ============================================================================
module tb_axi_lite_master_v2;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXIL_MST_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          ACLK;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  int checks    = 0;
  int failures  = 0;
  int cur_cyc   = 0;
  int to_pulses = 0;
  int to_cyc    = -1;

  // Reference model memory and the slave's own storage (word addressed).
  logic [DW-1:0] ref_mem   [4];
  logic [DW-1:0] slave_mem [4];

  axi_lite_master_v2 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Watchdog pulse monitor, sampled 1 ns after the falling edge.
  always begin
    @(negedge ACLK);
    #1;
    if (timeout === 1'b1) begin
      to_pulses++;
      to_cyc = cur_cyc;
    end
  end

  // --------------------------------------------------------------------------
  // One full transaction: issue command, act as slave, consume response.
  // Cycle 0 is the acceptance cycle; outputs are sampled at each falling edge.
  // --------------------------------------------------------------------------
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st,
                         input int aw_lat, input int w_lat, input int b_lat,
                         input int ar_lat, input int r_lat,
                         input logic [1:0] resp, input int hold, input bit early_b,
                         output int aw_cyc, output int w_cyc, output int rsp_cyc);
    int awc = 0, wc = 0, bc = 0, arc = 0, rc = 0, held = 0;
    bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, taken = 0, done = 0;
    bit aw_p, w_p, b_p, ar_p, r_p, taken_p, data_p, applied = 0;
    bit exp_bready, exp_rready, exp_rv;
    int idx;
    logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
    logic [DW-1:0] cap_wdata = '0, exp_rdata;
    logic [SW-1:0] cap_wstrb = '0;
    aw_cyc = -1; w_cyc = -1; rsp_cyc = -1;
    idx = int'(addr) >> 2;
    if (wr) begin
      for (int i = 0; i < SW; i++)
        if (st[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
      exp_rdata = '0;
    end else begin
      exp_rdata = ref_mem[idx];
    end

    @(negedge ACLK);
    cur_cyc = 0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL cmd_ready_before_accept got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;

    for (int cyc = 1; cyc <= 120 && !done; cyc++) begin
      @(negedge ACLK);
      cur_cyc = cyc;
      aw_p = aw_hs; w_p = w_hs; b_p = b_hs; ar_p = ar_hs; r_p = r_hs; taken_p = taken;
      data_p = wr ? b_p : r_p;
      AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
      rsp_ready = 1'b0;
      BRESP = 2'($urandom); RRESP = 2'($urandom); RDATA = $urandom;
      if (cyc == 1) begin
        // Captured command must not depend on the bus after acceptance.
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
      end

      if (wr) begin
        checks++;
        if (ARVALID !== 1'b0 || RREADY !== 1'b0) begin
          failures++; $display("FAIL rd_quiet_in_write cyc=%0d arvalid=%b rready=%b exp=0/0", cyc, ARVALID, RREADY);
        end
        checks++;
        if (AWVALID !== (aw_p ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL awvalid cyc=%0d got=%b exp=%b", cyc, AWVALID, !aw_p);
        end
        if (!aw_p) begin
          if (awc >= aw_lat) begin
            AWREADY = 1'b1; aw_hs = 1; aw_cyc = cyc; cap_awaddr = AWADDR;
            checks++;
            if (AWADDR !== addr) begin
              failures++; $display("FAIL awaddr got=%h exp=%h", AWADDR, addr);
            end
          end else awc++;
        end
        checks++;
        if (WVALID !== (w_p ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL wvalid cyc=%0d got=%b exp=%b", cyc, WVALID, !w_p);
        end
        if (!w_p) begin
          if (wc >= w_lat) begin
            WREADY = 1'b1; w_hs = 1; w_cyc = cyc; cap_wdata = WDATA; cap_wstrb = WSTRB;
            checks++;
            if (WDATA !== wd || WSTRB !== st) begin
              failures++; $display("FAIL wdata_wstrb got=%h/%h exp=%h/%h", WDATA, WSTRB, wd, st);
            end
          end else wc++;
        end
        if (aw_p && w_p && !applied) begin
          for (int i = 0; i < SW; i++)
            if (cap_wstrb[i]) slave_mem[int'(cap_awaddr) >> 2][8*i +: 8] = cap_wdata[8*i +: 8];
          applied = 1;
        end
        exp_bready = aw_p && w_p && !b_p;
        checks++;
        if (BREADY !== exp_bready) begin
          failures++; $display("FAIL bready cyc=%0d got=%b exp=%b", cyc, BREADY, exp_bready);
        end
        if (!b_p && (early_b || (aw_p && w_p && bc >= b_lat))) begin
          BVALID = 1'b1; BRESP = resp;
          if (exp_bready) b_hs = 1;
        end else if (exp_bready) bc++;
      end else begin
        checks++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b0) begin
          failures++; $display("FAIL wr_quiet_in_read cyc=%0d aw=%b w=%b b=%b exp=0/0/0", cyc, AWVALID, WVALID, BREADY);
        end
        checks++;
        if (ARVALID !== (ar_p ? 1'b0 : 1'b1)) begin
          failures++; $display("FAIL arvalid cyc=%0d got=%b exp=%b", cyc, ARVALID, !ar_p);
        end
        if (!ar_p) begin
          if (arc >= ar_lat) begin
            ARREADY = 1'b1; ar_hs = 1; cap_araddr = ARADDR;
            checks++;
            if (ARADDR !== addr) begin
              failures++; $display("FAIL araddr got=%h exp=%h", ARADDR, addr);
            end
          end else arc++;
        end
        exp_rready = ar_p && !r_p;
        checks++;
        if (RREADY !== exp_rready) begin
          failures++; $display("FAIL rready cyc=%0d got=%b exp=%b", cyc, RREADY, exp_rready);
        end
        if (exp_rready) begin
          if (rc >= r_lat) begin
            RVALID = 1'b1; RDATA = slave_mem[int'(cap_araddr) >> 2]; RRESP = resp; r_hs = 1;
          end else rc++;
        end
      end

      exp_rv = data_p && !taken_p;
      checks++;
      if (rsp_valid !== exp_rv) begin
        failures++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        if (rsp_cyc < 0) rsp_cyc = cyc;
        checks++;
        if (rsp_write !== wr || rsp_resp !== resp || rsp_rdata !== exp_rdata) begin
          failures++;
          $display("FAIL rsp_fields cyc=%0d got=w%b r%h d%h exp=w%b r%h d%h",
                   cyc, rsp_write, rsp_resp, rsp_rdata, wr, resp, exp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
          failures++; $display("FAIL cmd_ready_during_rsp got=%b exp=0", cmd_ready);
        end
        if (held >= hold) begin
          rsp_ready = 1'b1; taken = 1;
        end else begin
          held++;
          cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
          cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
        end
      end
      if (taken_p) begin
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++; $display("FAIL cmd_ready_after_rsp got=%b exp=1", cmd_ready);
        end
        done = 1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL txn_budget got=unfinished exp=finished addr=%h wr=%b", addr, wr);
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b%b%b exp=100", cmd_ready, rsp_valid, timeout);
    end
    checks++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
      failures++; $display("FAIL reset_axi_handshake got=%b exp=00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    checks++;
    if (rsp_write !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_fields got=%b/%h/%h exp=0/0/0", rsp_write, rsp_rdata, rsp_resp);
    end
    checks++;
    if (AWADDR !== '0 || ARADDR !== '0 || WDATA !== '0 || WSTRB !== '0 ||
        AWPROT !== 3'b000 || ARPROT !== 3'b000) begin
      failures++; $display("FAIL reset_axi_payload got=%h/%h/%h/%h/%h/%h exp=0", AWADDR, ARADDR, WDATA, WSTRB, AWPROT, ARPROT);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL cmd_ready_after_release got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    int a, w, r;
    run_txn(1'b1, 4'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, a, w, r);
    checks++;
    if (a != 1 || w != 1 || r != 3) begin
      failures++; $display("FAIL write_latency got=aw%0d w%0d rsp%0d exp=aw1 w1 rsp3", a, w, r);
    end
  endtask

  task automatic test_write_w_first();
    int a, w, r;
    run_txn(1'b1, 4'h4, 32'hA5A55A5A, 4'h5, 3, 0, 0, 0, 0, 2'b10, 0, 1'b0, a, w, r);
    checks++;
    if (a != 4 || w != 1) begin
      failures++; $display("FAIL w_before_aw_order got=aw%0d w%0d exp=aw4 w1", a, w);
    end
  endtask

  task automatic test_write_early_b();
    int a, w, r;
    run_txn(1'b1, 4'h0, 32'h0BADF00D, 4'hC, 1, 2, 0, 0, 0, 2'b01, 0, 1'b1, a, w, r);
    checks++;
    if (r != 5) begin
      failures++; $display("FAIL early_b_latency got=rsp%0d exp=rsp5", r);
    end
  endtask

  task automatic test_read();
    int a, w, r;
    ref_mem[3] = 32'h12345678;
    slave_mem[3] = 32'h12345678;
    run_txn(1'b0, 4'hC, '0, '0, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0, a, w, r);
    checks++;
    if (r != 3) begin
      failures++; $display("FAIL read_latency got=rsp%0d exp=rsp3", r);
    end
    run_txn(1'b0, 4'hC, '0, '0, 0, 0, 0, 2, 5, 2'b00, 0, 1'b0, a, w, r);
    checks++;
    if (r != 10) begin
      failures++; $display("FAIL read_wait_latency got=rsp%0d exp=rsp10", r);
    end
    run_txn(1'b0, 4'h4, '0, '0, 0, 0, 0, 1, 1, 2'b11, 0, 1'b0, a, w, r);
  endtask

  task automatic test_rsp_hold();
    int a, w, r;
    run_txn(1'b1, 4'hC, 32'hCAFEF00D, 4'h3, 0, 1, 2, 0, 0, 2'b00, 4, 1'b0, a, w, r);
    run_txn(1'b0, 4'hC, '0, '0, 0, 0, 0, 0, 1, 2'b00, 4, 1'b0, a, w, r);
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    checks++;
    if (AWVALID !== 1'b1 || WVALID !== 1'b1) begin
      failures++; $display("FAIL mid_valids_before_reset got=%b%b exp=11", AWVALID, WVALID);
    end
    @(negedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    checks++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset_drop got=aw%b w%b cr%b rv%b exp=aw0 w0 cr1 rv0", AWVALID, WVALID, cmd_ready, rsp_valid);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
        failures++; $display("FAIL post_reset_idle got=rv%b cr%b aw%b w%b exp=rv0 cr1 aw0 w0", rsp_valid, cmd_ready, AWVALID, WVALID);
      end
    end
  endtask

  task automatic test_random();
    int a, w, r;
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom), $urandom_range(0, 2), 1'($urandom), a, w, r);
    end
  endtask

`ifdef AXIL_MST_TIMEOUT_EN
  task automatic test_timeout();
    int a, w, r, before;
    before = to_pulses;
    checks++;
    if (before != 0) begin
      failures++; $display("FAIL no_early_timeout got=%0d exp=0", before);
    end
    run_txn(1'b1, 4'h4, 32'h55AA55AA, 4'hF, 0, 0, 40, 0, 0, 2'b00, 0, 1'b0, a, w, r);
    checks++;
    if (to_pulses - before != 1 || to_cyc != 16) begin
      failures++; $display("FAIL timeout_pulse got=n%0d cyc%0d exp=n1 cyc16", to_pulses - before, to_cyc);
    end
    checks++;
    if (r != 43) begin
      failures++; $display("FAIL timeout_completion got=rsp%0d exp=rsp43", r);
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (to_pulses != 0) begin
      failures++; $display("FAIL timeout_disabled got=%0d exp=0", to_pulses);
    end
  endtask
`endif

  initial begin
    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    test_reset();
    test_write_zero_wait();
    test_write_w_first();
    test_write_early_b();
    test_read();
    test_rsp_hold();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_v2.md
Name: axi_lite_master_v2

Overview:
- Parametrised AXI4-Lite master; converts a simple command/response handshake from local logic (CPU bridge, UART command decoder) into single AXI4-Lite read or write transactions.
- Successor to the fixed 4-bit-address / 32-bit-data master. Adds:
  - configurable address and data width
  - byte strobes
  - registered command capture
  - independent AW/W completion tracking
  - response-code return with a held response handshake
- One transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 4, AXI address width in bits (2..32).
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog threshold in ACLK cycles; used only with AXIL_MST_TIMEOUT_EN.

Ports:
- ACLK  input  1  clock
- ARESET  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- cmd_wstrb  input  DATA_WIDTH/8  write byte strobes
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_write  output  1  response belongs to a write
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
- rsp_resp  output  2  BRESP/RRESP of the transaction
- timeout  output  1  one-cycle watchdog pulse
- AWADDR  output  ADDR_WIDTH
- AWPROT  output  3
- AWVALID  output  1
- AWREADY  input  1
- WDATA  output  DATA_WIDTH
- WSTRB  output  DATA_WIDTH/8
- WVALID  output  1
- WREADY  input  1
- BRESP  input  2
- BVALID  input  1
- BREADY  output  1
- ARADDR  output  ADDR_WIDTH
- ARPROT  output  3
- ARVALID  output  1
- ARREADY  input  1
- RDATA  input  DATA_WIDTH
- RRESP  input  2
- RVALID  input  1
- RREADY  output  1

Behaviour:
- Reset (async, ARESET=1): state=IDLE.
  - All VALID/READY outputs 0, except cmd_ready=1 in IDLE.
  - rsp_valid=0; rsp_rdata, rsp_resp, rsp_write = 0; timeout=0.
  - AWADDR, ARADDR, WDATA, WSTRB = 0. AWPROT = ARPROT = 3'b000 (constant).
- FSM states: IDLE, WR (address+data phase), WR_B, RD_A, RD_R, RSP.
- cmd_ready = (state==IDLE). On cmd_valid&cmd_ready:
  - addr, wdata and wstrb are registered; the command interface may change afterwards.
  - write -> WR; read -> RD_A.
- WR: AWVALID and WVALID both assert the cycle after acceptance.
  - Flags aw_done and w_done set on their respective handshakes. Each VALID drops the cycle after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Both done -> WR_B.
- WR_B: BREADY=1. On BVALID:
  - rsp_resp=BRESP, rsp_write=1, rsp_rdata=0 -> RSP.
  - BVALID arriving before the AW/W handshakes finish is ignored (BREADY=0 outside WR_B).
- RD_A: ARVALID=1 until ARREADY, then RD_R.
- RD_R: RREADY=1. On RVALID:
  - rsp_rdata=RDATA, rsp_resp=RRESP, rsp_write=0 -> RSP.
- RSP: rsp_valid=1, all response fields stable until rsp_ready. On rsp_ready -> IDLE.
  - A new command is accepted no earlier than the cycle after rsp_ready.
- AXI rule: once asserted, a VALID is never deasserted before its handshake, including under the watchdog.
- Minimum latency with zero-wait slave:
  - write: accept T0, AW/W handshake T1, B T2, rsp_valid T3.
  - read: accept T0, AR T1, R T2, rsp_valid T3.
- SLVERR/DECERR are passed through unchanged; the FSM flow is identical to OKAY.
- Reset mid-transaction: immediate return to IDLE, all VALIDs drop asynchronously, any pending response is discarded.

Optional Feature:
- Macro AXIL_MST_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on command accept and counts every cycle in WR, WR_B, RD_A, RD_R (not RSP).
  - When the count reaches TIMEOUT_CYCLES, timeout pulses for exactly one cycle, once per transaction.
  - The transaction keeps waiting and completes normally if the slave eventually responds.
- Not defined: timeout tied to 0, counter absent.

Test Plan:
- Write addr=4'h8, wdata=32'hDEADBEEF, wstrb=4'hF, zero-wait slave, BRESP=00 -> AWADDR=8 and WDATA=DEADBEEF handshake at T1; rsp_valid at T3 with rsp_write=1, rsp_resp=00.
- Write, slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held; single B accepted; rsp_resp=BRESP=10 propagated.
- Read addr=4'hC, slave returns RDATA=32'h12345678 after 5 wait cycles with RRESP=00 -> ARVALID held until ARREADY; rsp_rdata=12345678, rsp_write=0.
- rsp_ready held low 4 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0 throughout; next command accepted the cycle after rsp_ready.
- ARESET pulsed while AWVALID=1 and WVALID=1 -> both drop immediately; state IDLE; cmd_ready=1 after release; no rsp_valid.
- With AXIL_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave withholds BVALID 40 cycles -> exactly one timeout pulse 16 cycles after accept; normal response when BVALID arrives.
